// File: rtl/arb_req_agent_if.sv
// Handshake bundle between an arbiter requester agent and its neighbours.
// Ports: cmd push side, req/gnt pair, issued bus beat, and status flags.
interface arb_req_agent_if #(
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
);
   localparam int LW = $clog2(MAX_BURST);

   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic [DW-1:0] cmd_data_i;
   logic [LW-1:0] cmd_len_i;
   logic          req_o;
   logic          gnt_i;
   logic          bus_valid_o;
   logic [DW-1:0] bus_data_o;
   logic          bus_last_o;
   logic          busy_o;
   logic          err_o;

   // Agent side.
   modport slave (
      input  cmd_valid_i,
      input  cmd_data_i,
      input  cmd_len_i,
      input  gnt_i,
      output cmd_ready_o,
      output req_o,
      output bus_valid_o,
      output bus_data_o,
      output bus_last_o,
      output busy_o,
      output err_o
   );

   // Local logic / arbiter side.
   modport master (
      output cmd_valid_i,
      output cmd_data_i,
      output cmd_len_i,
      output gnt_i,
      input  cmd_ready_o,
      input  req_o,
      input  bus_valid_o,
      input  bus_data_o,
      input  bus_last_o,
      input  busy_o,
      input  err_o
   );
endinterface

// File: rtl/arb_req_agent.sv
// Requester client for a fixed-priority arbiter: queues burst commands,
// requests the bus, and issues one beat per granted cycle.
// Ports: clk_i, rst_ni (sync, active-low), bus (arb_req_agent_if.slave).
module arb_req_agent #(
   parameter int DW        = 8,
   parameter int DEPTH     = 4,
   parameter int MAX_BURST = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   arb_req_agent_if.slave     bus
);
   localparam int LW = $clog2(MAX_BURST);
   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARB  = 2'd1;
   localparam logic [1:0] S_REL  = 2'd2;

   logic [DW-1:0] r_fifo_data [DEPTH];
   logic [LW-1:0] r_fifo_len  [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [LW-1:0] r_beat_cnt;
   logic          r_err;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_req;
   logic          w_beat;
   logic          w_last;
   logic [DW-1:0] w_head_data;
   logic [LW-1:0] w_head_len;

   assign w_full  = (r_count == (AW+1)'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = bus.cmd_valid_i && !w_full;

   assign w_head_data = r_fifo_data[r_rptr];
   assign w_head_len  = r_fifo_len[r_rptr];

   // req is a pure state decode so it never glitches with gnt.
   assign w_req  = (r_state == S_ARB);
   assign w_beat = w_req && bus.gnt_i;
   assign w_last = w_beat && (r_beat_cnt == w_head_len);
   assign w_pop  = w_last;

   // Storage needs no reset: entries are only read while the queue
   // holds valid data.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_data[r_wptr] <= bus.cmd_data_i;
         r_fifo_len[r_wptr]  <= bus.cmd_len_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (!w_empty) w_state_nxt = S_ARB;
         S_ARB:  if (w_last)   w_state_nxt = S_REL;
         // A command accepted during the release cycle still counts.
         S_REL:  w_state_nxt = (!w_empty || w_push) ? S_ARB : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_beat_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_last)      r_beat_cnt <= '0;
         else if (w_beat) r_beat_cnt <= r_beat_cnt + 1'b1;
      end
   end

   // Grant without an outstanding request is a sticky arbiter fault.
   always_ff @(posedge clk_i) begin
      if (!rst_ni)                   r_err <= 1'b0;
      else if (bus.gnt_i && !w_req)  r_err <= 1'b1;
   end

   assign bus.cmd_ready_o = !w_full;
   assign bus.req_o       = w_req;
   assign bus.bus_valid_o = w_beat;
   assign bus.bus_data_o  = w_beat ? (w_head_data + DW'(r_beat_cnt)) : '0;
   assign bus.bus_last_o  = w_last;
   assign bus.busy_o      = (r_state != S_IDLE) || !w_empty;
   assign bus.err_o       = r_err;

endmodule

// File: tb/tb_arb_req_agent.sv
// Directed vector bench for arb_req_agent.
// Ports: drives the agent through arb_req_agent_if; no external I/O.
module tb_arb_req_agent;
   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   arb_req_agent_if #(.DW(8), .MAX_BURST(4)) u_if ();

   arb_req_agent #(
      .DW(8),
      .DEPTH(4),
      .MAX_BURST(4)
   ) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic       cv;
      logic [7:0] cd;
      logic [1:0] cl;
      logic       gnt;
      logic       req;
      logic       bv;
      logic [7:0] bd;
      logic       bl;
      logic       busy;
      logic       rdy;
      logic       err;
   } vec_t;

   vec_t tbl[$];

   task automatic v(
      input logic r, input logic cv, input logic [7:0] cd,
      input logic [1:0] cl, input logic g,
      input logic rq, input logic bv, input logic [7:0] bd,
      input logic bl, input logic by, input logic rd, input logic er
   );
      vec_t t;
      t.rst_n = r;  t.cv = cv;  t.cd = cd;  t.cl = cl;  t.gnt = g;
      t.req = rq;   t.bv = bv;  t.bd = bd;  t.bl = bl;
      t.busy = by;  t.rdy = rd; t.err = er;
      tbl.push_back(t);
   endtask

   task automatic chk(
      input string nm, input int idx,
      input logic [31:0] got, input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @%0d: got %0h want %0h", nm, idx, got, exp);
      end
   endtask

   int n;

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b0;
      u_if.cmd_valid_i = 1'b0;
      u_if.cmd_data_i  = '0;
      u_if.cmd_len_i   = '0;
      u_if.gnt_i       = 1'b0;

      //     rst cv cd    cl g   req bv bd    bl bsy rdy err
      // reset state, single beat
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 1, 0);
      v(1, 1, 8'h10, 0, 0,  0, 0, 8'h00, 0, 0, 1, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 1,  1, 1, 8'h10, 1, 1, 1, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 1, 0);
      // burst with data wrap
      v(1, 1, 8'hFE, 3, 0,  0, 0, 8'h00, 0, 0, 1, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 1,  1, 1, 8'hFE, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 1,  1, 1, 8'hFF, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 1,  1, 1, 8'h00, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 1,  1, 1, 8'h01, 1, 1, 1, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 1, 0);
      // preemption gap mid-burst
      v(1, 1, 8'h20, 3, 0,  0, 0, 8'h00, 0, 0, 1, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 1,  1, 1, 8'h20, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 1,  1, 1, 8'h21, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 1,  1, 1, 8'h22, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 1,  1, 1, 8'h23, 1, 1, 1, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 1, 0);
      // fill FIFO, push while full is refused, drain in order
      v(1, 1, 8'hA0, 0, 0,  0, 0, 8'h00, 0, 0, 1, 0);
      v(1, 1, 8'hA1, 0, 0,  0, 0, 8'h00, 0, 1, 1, 0);
      v(1, 1, 8'hA2, 0, 0,  1, 0, 8'h00, 0, 1, 1, 0);
      v(1, 1, 8'hA3, 0, 0,  1, 0, 8'h00, 0, 1, 1, 0);
      v(1, 1, 8'hEE, 0, 0,  1, 0, 8'h00, 0, 1, 0, 0);
      v(1, 0, 8'h00, 0, 1,  1, 1, 8'hA0, 1, 1, 0, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 1,  1, 1, 8'hA1, 1, 1, 1, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 1,  1, 1, 8'hA2, 1, 1, 1, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 1,  1, 1, 8'hA3, 1, 1, 1, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 1, 0);
      // push during release goes straight back to ARB
      v(1, 1, 8'h30, 0, 0,  0, 0, 8'h00, 0, 0, 1, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 1,  1, 1, 8'h30, 1, 1, 1, 0);
      v(1, 1, 8'h40, 0, 0,  0, 0, 8'h00, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 1,  1, 1, 8'h40, 1, 1, 1, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 1, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 1, 0);
      // grant while idle: sticky error, no beat
      v(1, 0, 8'h00, 0, 1,  0, 0, 8'h00, 0, 0, 1, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 1, 1);
      v(1, 1, 8'h50, 0, 0,  0, 0, 8'h00, 0, 0, 1, 1);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 1, 1);
      v(1, 0, 8'h00, 0, 1,  1, 1, 8'h50, 1, 1, 1, 1);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 1, 1);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 1, 1);
      // reset in the middle of a burst with commands queued
      v(1, 1, 8'h60, 3, 0,  0, 0, 8'h00, 0, 0, 1, 1);
      v(1, 1, 8'h70, 0, 0,  0, 0, 8'h00, 0, 1, 1, 1);
      v(1, 1, 8'h80, 0, 1,  1, 1, 8'h60, 0, 1, 1, 1);
      v(1, 0, 8'h00, 0, 1,  1, 1, 8'h61, 0, 1, 1, 1);
      v(0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 1, 1, 1);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 1, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 1, 0);
      v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 1, 0);

      repeat (2) @(posedge clk);

      foreach (tbl[i]) begin
         @(negedge clk);
         rst_n            = tbl[i].rst_n;
         u_if.cmd_valid_i = tbl[i].cv;
         u_if.cmd_data_i  = tbl[i].cd;
         u_if.cmd_len_i   = tbl[i].cl;
         u_if.gnt_i       = tbl[i].gnt;
         #1;
         chk("req",   i, 32'(u_if.req_o),       32'(tbl[i].req));
         chk("valid", i, 32'(u_if.bus_valid_o), 32'(tbl[i].bv));
         chk("data",  i, 32'(u_if.bus_data_o),  32'(tbl[i].bd));
         chk("last",  i, 32'(u_if.bus_last_o),  32'(tbl[i].bl));
         chk("busy",  i, 32'(u_if.busy_o),      32'(tbl[i].busy));
         chk("ready", i, 32'(u_if.cmd_ready_o), 32'(tbl[i].rdy));
         chk("err",   i, 32'(u_if.err_o),       32'(tbl[i].err));
      end

      // Two-beat burst with a bounded wait for the request.
      @(negedge clk);
      rst_n            = 1'b1;
      u_if.gnt_i       = 1'b0;
      u_if.cmd_valid_i = 1'b1;
      u_if.cmd_data_i  = 8'h7F;
      u_if.cmd_len_i   = 2'd1;
      @(negedge clk);
      u_if.cmd_valid_i = 1'b0;
      n = 0;
      #1;
      while (u_if.req_o !== 1'b1 && n < 8) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("req_lat", 100, 32'(n), 32'd1);
      u_if.gnt_i = 1'b1;
      #1;
      chk("b0_valid", 101, 32'(u_if.bus_valid_o), 32'd1);
      chk("b0_data",  101, 32'(u_if.bus_data_o),  32'h7F);
      chk("b0_last",  101, 32'(u_if.bus_last_o),  32'd0);
      @(negedge clk);
      #1;
      chk("b1_data",  102, 32'(u_if.bus_data_o),  32'h80);
      chk("b1_last",  102, 32'(u_if.bus_last_o),  32'd1);
      @(negedge clk);
      u_if.gnt_i = 1'b0;
      #1;
      chk("rel_req",  103, 32'(u_if.req_o),       32'd0);
      @(negedge clk);
      #1;
      chk("idle_busy", 104, 32'(u_if.busy_o),     32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
